// File: rtl/atm_txn_engine.sv
// Multi-account ATM transaction controller: PIN authentication with lockout, per-session
// deposit/withdraw/balance/transfer, session withdrawal cap, cash tracking and inactivity timeout.
module atm_txn_engine #(
  parameter int unsigned NUM_ACCOUNTS   = 8,
  parameter int unsigned BAL_W          = 16,
  parameter int unsigned AMT_W          = 15,
  parameter int unsigned PWD_W          = 16,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned SESSION_LIMIT  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [PWD_W-1:0] cfg_pwd,
  input  logic [BAL_W-1:0] cfg_bal,
  input  logic             atm_init,
  input  logic [BAL_W-1:0] atm_capacity,
  input  logic             insert,
  input  logic [IDX_W-1:0] card_idx,
  input  logic             card_valid,
  input  logic [PWD_W-1:0] password,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [IDX_W-1:0] dest_idx,
  input  logic             enter,
  input  logic             cancel,
  output logic [BAL_W-1:0] balance_out,
  output logic [BAL_W-1:0] cash_avail,
  output logic             done,
  output logic             err_valid,
  output logic [3:0]       err_code,
  output logic             card_eject,
  output logic             card_retained,
  output logic             busy
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TOT_W = $clog2(SESSION_LIMIT + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SUM_W = BAL_W + 1;

  localparam logic [3:0] ErrBadCard  = 4'd1;
  localparam logic [3:0] ErrBadPwd   = 4'd2;
  localparam logic [3:0] ErrLocked   = 4'd3;
  localparam logic [3:0] ErrInsuff   = 4'd4;
  localparam logic [3:0] ErrNoCash   = 4'd5;
  localparam logic [3:0] ErrLimit    = 4'd6;
  localparam logic [3:0] ErrOverflow = 4'd7;
  localparam logic [3:0] ErrBadDest  = 4'd8;
  localparam logic [3:0] ErrTimeout  = 4'd9;

  typedef enum logic [1:0] {StIdle, StAuth, StMenu, StExec} state_e;

  state_e                  state_q, state_d;
  logic [BAL_W-1:0]        bal_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        bal_d [NUM_ACCOUNTS];
  logic [PWD_W-1:0]        pwd_q [NUM_ACCOUNTS];
  logic [PWD_W-1:0]        pwd_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
  logic [IDX_W-1:0]        src_q, src_d, dest_q, dest_d;
  logic [TRY_W-1:0]        tries_q, tries_d;
  logic [TOT_W-1:0]        tot_q, tot_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [1:0]              op_q, op_d;
  logic [AMT_W-1:0]        amt_q, amt_d;
  logic [BAL_W-1:0]        balance_out_q, balance_out_d, cash_q, cash_d;
  logic                    done_q, done_d, err_valid_q, err_valid_d;
  logic [3:0]              err_code_q, err_code_d;
  logic                    eject_q, eject_d, retained_q, retained_d, busy_q, busy_d;

  // Operand arithmetic for EXEC, one bit wider than a balance to expose carry.
  logic [SUM_W-1:0] amt_ext, src_ext, dst_ext, dep_sum, xfer_sum;
  logic [BAL_W-1:0] src_bal, dst_bal, amt_bal;
  logic [31:0]      tot_sum;
  logic             timeout_hit, card_in_range, cfg_in_range, dest_bad;

  always_comb begin
    src_bal       = bal_q[src_q];
    dst_bal       = bal_q[dest_q];
    amt_bal       = BAL_W'(amt_q);
    amt_ext       = SUM_W'(amt_q);
    src_ext       = SUM_W'(src_bal);
    dst_ext       = SUM_W'(dst_bal);
    dep_sum       = src_ext + amt_ext;
    xfer_sum      = dst_ext + amt_ext;
    tot_sum       = 32'(tot_q) + 32'(amt_q);
    timeout_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    card_in_range = (32'(card_idx) < NUM_ACCOUNTS);
    cfg_in_range  = (32'(cfg_idx) < NUM_ACCOUNTS);
    dest_bad      = (32'(dest_q) >= NUM_ACCOUNTS) || (dest_q == src_q);
  end

  always_comb begin
    state_d       = state_q;
    bal_d         = bal_q;
    pwd_d         = pwd_q;
    lock_d        = lock_q;
    src_d         = src_q;
    dest_d        = dest_q;
    tries_d       = tries_q;
    tot_d         = tot_q;
    tmo_d         = '0;
    op_d          = op_q;
    amt_d         = amt_q;
    balance_out_d = balance_out_q;
    cash_d        = cash_q;
    done_d        = 1'b0;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;
    eject_d       = 1'b0;
    retained_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_we && cfg_in_range) begin
          pwd_d[cfg_idx]  = cfg_pwd;
          bal_d[cfg_idx]  = cfg_bal;
          lock_d[cfg_idx] = 1'b0;
        end
        if (atm_init) cash_d = atm_capacity;
        if (insert) begin
          if (!card_valid || !card_in_range) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrBadCard;
            eject_d     = 1'b1;
          end else if (lock_q[card_idx]) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrLocked;
            retained_d  = 1'b1;
          end else begin
            src_d   = card_idx;
            tries_d = '0;
            state_d = StAuth;
          end
        end
      end
      StAuth: begin
        if (timeout_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
          eject_d     = 1'b1;
          state_d     = StIdle;
        end else if (cancel) begin
          eject_d = 1'b1;
          state_d = StIdle;
        end else if (enter) begin
          if (password == pwd_q[src_q]) begin
            done_d  = 1'b1;
            tot_d   = '0;
            state_d = StMenu;
          end else if (tries_q >= TRY_W'(MAX_TRIES - 1)) begin
            lock_d[src_q] = 1'b1;
            err_valid_d   = 1'b1;
            err_code_d    = ErrLocked;
            retained_d    = 1'b1;
            state_d       = StIdle;
          end else begin
            tries_d     = tries_q + 1'b1;
            err_valid_d = 1'b1;
            err_code_d  = ErrBadPwd;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StMenu: begin
        if (timeout_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
          eject_d     = 1'b1;
          state_d     = StIdle;
        end else if (cancel) begin
          eject_d = 1'b1;
          state_d = StIdle;
        end else if (enter) begin
          op_d    = op;
          amt_d   = amount;
          dest_d  = dest_idx;
          state_d = StExec;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StExec: begin
        state_d = StMenu;
        done_d  = 1'b1;
        unique case (op_q)
          2'd0: begin
            if (dep_sum[BAL_W]) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrOverflow;
            end else begin
              bal_d[src_q]  = dep_sum[BAL_W-1:0];
              balance_out_d = dep_sum[BAL_W-1:0];
            end
          end
          2'd1: begin
            if (tot_sum > SESSION_LIMIT) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrLimit;
            end else if (amt_ext > src_ext) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrInsuff;
            end else if (amt_bal > cash_q) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrNoCash;
            end else begin
              bal_d[src_q]  = src_bal - amt_bal;
              balance_out_d = src_bal - amt_bal;
              cash_d        = cash_q - amt_bal;
              tot_d         = tot_q + TOT_W'(amt_q);
            end
          end
          2'd2: balance_out_d = src_bal;
          2'd3: begin
            if (dest_bad) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrBadDest;
            end else if (amt_ext > src_ext) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrInsuff;
            end else if (xfer_sum[BAL_W]) begin
              done_d      = 1'b0;
              err_valid_d = 1'b1;
              err_code_d  = ErrOverflow;
            end else begin
              bal_d[src_q]  = src_bal - amt_bal;
              bal_d[dest_q] = xfer_sum[BAL_W-1:0];
              balance_out_d = src_bal - amt_bal;
            end
          end
        endcase
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bal_q         <= '{default: '0};
      pwd_q         <= '{default: '0};
      lock_q        <= '0;
      src_q         <= '0;
      dest_q        <= '0;
      tries_q       <= '0;
      tot_q         <= '0;
      tmo_q         <= '0;
      op_q          <= '0;
      amt_q         <= '0;
      balance_out_q <= '0;
      cash_q        <= '0;
      done_q        <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= '0;
      eject_q       <= 1'b0;
      retained_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bal_q         <= bal_d;
      pwd_q         <= pwd_d;
      lock_q        <= lock_d;
      src_q         <= src_d;
      dest_q        <= dest_d;
      tries_q       <= tries_d;
      tot_q         <= tot_d;
      tmo_q         <= tmo_d;
      op_q          <= op_d;
      amt_q         <= amt_d;
      balance_out_q <= balance_out_d;
      cash_q        <= cash_d;
      done_q        <= done_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      eject_q       <= eject_d;
      retained_q    <= retained_d;
      busy_q        <= busy_d;
    end
  end

  assign balance_out   = balance_out_q;
  assign cash_avail    = cash_q;
  assign done          = done_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign card_eject    = eject_q;
  assign card_retained = retained_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Scoreboard bench for atm_txn_engine: directed scenarios plus randomized sessions checked
// against an account-level reference model.
module tb_atm_txn_engine;

  localparam int NA = 8;
  localparam int SL = 1000;
  localparam int TO = 1024;
  localparam int MT = 3;
  localparam int BMAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, atm_init, insert, card_valid, enter, cancel;
  logic [2:0]  cfg_idx, card_idx, dest_idx;
  logic [15:0] cfg_pwd, cfg_bal, atm_capacity, password;
  logic [1:0]  op;
  logic [14:0] amount;
  logic [15:0] balance_out, cash_avail;
  logic        done, err_valid, card_eject, card_retained, busy;
  logic [3:0]  err_code;

  atm_txn_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pwd(cfg_pwd),
    .cfg_bal(cfg_bal), .atm_init(atm_init), .atm_capacity(atm_capacity), .insert(insert),
    .card_idx(card_idx), .card_valid(card_valid), .password(password), .op(op),
    .amount(amount), .dest_idx(dest_idx), .enter(enter), .cancel(cancel),
    .balance_out(balance_out), .cash_avail(cash_avail), .done(done), .err_valid(err_valid),
    .err_code(err_code), .card_eject(card_eject), .card_retained(card_retained), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic       err;
    logic [3:0] code;
    logic       eject;
    logic       ret;
    int         bal;
    int         cash;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: account records and session bookkeeping.
  int m_bal[NA];
  int m_pwd[NA];
  bit m_lock[NA];
  int m_cash, m_bout, m_src, m_tries, m_total;
  int m_sess; // 0 no card, 1 awaiting PIN, 2 logged in

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input bit d, input bit e, input int code, input bit ej, input bit rt);
    exp_t x;
    x.done = d; x.err = e; x.code = 4'(code); x.eject = ej; x.ret = rt;
    x.bal = m_bout; x.cash = m_cash;
    sbq.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && (done || err_valid || card_eject || card_retained)) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=d%0b e%0b c%0d ej%0b rt%0b required=none",
                   done, err_valid, err_code, card_eject, card_retained);
        end else begin
          x = sbq.pop_front();
          chk("done", int'(done), int'(x.done));
          chk("err_valid", int'(err_valid), int'(x.err));
          if (x.err) chk("err_code", int'(err_code), int'(x.code));
          chk("card_eject", int'(card_eject), int'(x.eject));
          chk("card_retained", int'(card_retained), int'(x.ret));
          chk("balance_out", int'(balance_out), x.bal);
          chk("cash_avail", int'(cash_avail), x.cash);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cfg_we = 0; atm_init = 0; insert = 0; card_valid = 0; enter = 0; cancel = 0;
    cfg_idx = 0; card_idx = 0; dest_idx = 0; cfg_pwd = 0; cfg_bal = 0;
    atm_capacity = 0; password = 0; op = 0; amount = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin m_bal[i] = 0; m_pwd[i] = 0; m_lock[i] = 0; end
    m_cash = 0; m_bout = 0; m_src = 0; m_tries = 0; m_total = 0; m_sess = 0;
  endtask

  task automatic cfg(input int idx, input int pwd, input int bal);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_pwd = 16'(pwd); cfg_bal = 16'(bal);
    if (m_sess == 0) begin m_pwd[idx] = pwd; m_bal[idx] = bal; m_lock[idx] = 0; end
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic init_cash(input int cap);
    @(negedge clk);
    atm_init = 1; atm_capacity = 16'(cap);
    if (m_sess == 0) m_cash = cap;
    @(negedge clk);
    atm_init = 0;
  endtask

  task automatic insert_card(input int idx, input bit valid);
    @(negedge clk);
    insert = 1; card_idx = 3'(idx); card_valid = valid;
    if (m_sess == 0) begin
      if (!valid) push(0, 1, 1, 1, 0);
      else if (m_lock[idx]) push(0, 1, 3, 0, 1);
      else begin m_sess = 1; m_src = idx; m_tries = 0; end
    end
    @(negedge clk);
    insert = 0; card_valid = 0;
    @(negedge clk);
  endtask

  task automatic enter_pwd(input int p);
    @(negedge clk);
    enter = 1; password = 16'(p);
    if (m_sess == 1) begin
      if (p == m_pwd[m_src]) begin
        m_sess = 2; m_total = 0; push(1, 0, 0, 0, 0);
      end else begin
        m_tries++;
        if (m_tries >= MT) begin
          m_lock[m_src] = 1; m_sess = 0; push(0, 1, 3, 0, 1);
        end else push(0, 1, 2, 0, 0);
      end
    end
    @(negedge clk);
    enter = 0;
    @(negedge clk);
  endtask

  task automatic model_op(input int o, input int amt, input int dst);
    int s;
    s = m_src;
    case (o)
      0: if (m_bal[s] + amt > BMAX) push(0, 1, 7, 0, 0);
         else begin m_bal[s] += amt; m_bout = m_bal[s]; push(1, 0, 0, 0, 0); end
      1: if (m_total + amt > SL) push(0, 1, 6, 0, 0);
         else if (amt > m_bal[s]) push(0, 1, 4, 0, 0);
         else if (amt > m_cash) push(0, 1, 5, 0, 0);
         else begin
           m_bal[s] -= amt; m_cash -= amt; m_total += amt; m_bout = m_bal[s];
           push(1, 0, 0, 0, 0);
         end
      2: begin m_bout = m_bal[s]; push(1, 0, 0, 0, 0); end
      default:
         if (dst >= NA || dst == s) push(0, 1, 8, 0, 0);
         else if (amt > m_bal[s]) push(0, 1, 4, 0, 0);
         else if (m_bal[dst] + amt > BMAX) push(0, 1, 7, 0, 0);
         else begin
           m_bal[s] -= amt; m_bal[dst] += amt; m_bout = m_bal[s]; push(1, 0, 0, 0, 0);
         end
    endcase
  endtask

  task automatic do_op(input int o, input int amt, input int dst, input bit with_cancel);
    @(negedge clk);
    enter = 1; cancel = with_cancel; op = 2'(o); amount = 15'(amt); dest_idx = 3'(dst);
    if (m_sess == 2) begin
      if (with_cancel) begin m_sess = 0; push(0, 0, 0, 1, 0); end
      else model_op(o, amt, dst);
    end
    @(negedge clk);
    enter = 0; cancel = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_session();
    @(negedge clk);
    cancel = 1;
    if (m_sess != 0) begin m_sess = 0; push(0, 0, 0, 1, 0); end
    @(negedge clk);
    cancel = 0;
    @(negedge clk);
  endtask

  task automatic rand_amount(output int amt);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) amt = 0;
    else if (r < 8) amt = $urandom_range(1, 1200);
    else amt = $urandom_range(0, 32767);
  endtask

  initial begin
    int n, amt, idx;
    idle_inputs();
    model_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_valid", int'(err_valid), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_eject", int'(card_eject), 0);
    chk("rst_retained", int'(card_retained), 0);
    chk("rst_balance_out", int'(balance_out), 0);
    chk("rst_cash", int'(cash_avail), 0);
    rst = 0;

    // Basic withdrawal.
    cfg(2, 'h1234, 500);
    init_cash(800);
    @(negedge clk);
    chk("cash_after_init", int'(cash_avail), 800);
    insert_card(2, 1);
    chk("busy_in_auth", int'(busy), 1);
    enter_pwd('h1234);
    do_op(1, 200, 0, 0);
    chk("withdraw_balance", int'(balance_out), 300);
    chk("withdraw_cash", int'(cash_avail), 600);
    end_session();
    chk("busy_after_cancel", int'(busy), 0);

    // Bad card, PIN lockout, re-insert on locked account, unlock by reconfiguration.
    insert_card(5, 0);
    insert_card(2, 1);
    enter_pwd('h1111);
    enter_pwd('h2222);
    enter_pwd('h3333);
    insert_card(2, 1);
    cfg(2, 'h1234, 300);
    insert_card(2, 1);
    enter_pwd('h1234);
    do_op(2, 0, 0, 0);
    end_session();

    // Session withdrawal cap.
    cfg(3, 'hbeef, 5000);
    init_cash(5000);
    insert_card(3, 1);
    enter_pwd('hbeef);
    do_op(1, 600, 0, 0);
    do_op(1, 500, 0, 0);
    do_op(1, 400, 0, 0);
    do_op(1, 0, 0, 0);
    end_session();

    // Transfer/deposit rejections leave memory untouched.
    cfg(1, 'h1111, 50);
    cfg(4, 'h4444, 65500);
    insert_card(1, 1);
    enter_pwd('h1111);
    do_op(3, 100, 4, 0);
    do_op(3, 10, 1, 0);
    do_op(3, 40, 4, 0);
    do_op(2, 0, 0, 0);
    end_session();
    insert_card(4, 1);
    enter_pwd('h4444);
    do_op(0, 100, 0, 0);
    do_op(0, 35, 0, 0);
    do_op(3, 500, 3, 0);
    do_op(2, 0, 0, 0);
    end_session();

    // Inactivity timeout in MENU.
    insert_card(1, 1);
    enter_pwd('h1111);
    m_sess = 0;
    push(0, 1, 9, 1, 0);
    n = 0;
    while (!err_valid && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TO - 1);
    chk("timeout_busy", int'(busy), 0);

    // enter with cancel in MENU: eject only, no op.
    insert_card(1, 1);
    enter_pwd('h1111);
    do_op(1, 10, 0, 1);
    insert_card(1, 1);
    enter_pwd('h1111);
    do_op(2, 0, 0, 0);

    // Asynchronous reset while EXEC is in progress.
    @(negedge clk);
    enter = 1; op = 2'd1; amount = 15'd5;
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rstx_busy", int'(busy), 0);
    chk("rstx_done", int'(done), 0);
    chk("rstx_err_valid", int'(err_valid), 0);
    chk("rstx_err_code", int'(err_code), 0);
    chk("rstx_eject", int'(card_eject), 0);
    chk("rstx_retained", int'(card_retained), 0);
    chk("rstx_balance_out", int'(balance_out), 0);
    chk("rstx_cash", int'(cash_avail), 0);
    @(negedge clk);
    enter = 0;
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst = 0;
    insert_card(1, 1);
    enter_pwd(0);
    do_op(2, 0, 0, 0);
    end_session();

    // Randomized sessions.
    for (int i = 0; i < NA; i++)
      cfg(i, $urandom_range(0, 65535),
          ($urandom_range(0, 3) == 0) ? $urandom_range(64000, 65535) : $urandom_range(0, 3000));
    init_cash($urandom_range(0, 4000));
    for (int s = 0; s < 40; s++) begin
      if (s % 8 == 7) begin
        idx = $urandom_range(0, NA - 1);
        cfg(idx, $urandom_range(0, 65535), $urandom_range(0, 3000));
        init_cash($urandom_range(0, 4000));
      end
      idx = $urandom_range(0, NA - 1);
      insert_card(idx, $urandom_range(0, 9) != 0);
      for (int g = 0; g < 4 && m_sess == 1; g++) begin
        if ($urandom_range(0, 9) < 6) enter_pwd(m_pwd[idx]);
        else enter_pwd((m_pwd[idx] + 1 + $urandom_range(0, 100)) % 65536);
      end
      for (int k = 0, nops = $urandom_range(1, 6); k < nops && m_sess == 2; k++) begin
        case ($urandom_range(0, 19))
          0: do_op(1, 1, 0, 1);
          1: insert_card($urandom_range(0, NA - 1), 1);
          2: cfg($urandom_range(0, NA - 1), 0, 0);
          default: begin
            rand_amount(amt);
            do_op($urandom_range(0, 3), amt, $urandom_range(0, NA - 1), 0);
          end
        endcase
      end
      if (m_sess != 0) end_session();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_txn_engine.md
# atm_txn_engine

Parametrised multi-account ATM transaction controller, the next generation of the single-account ATM controller. It holds NUM_ACCOUNTS balance/password records internally and authenticates with PIN-retry lockout. It runs multiple operations per card session (deposit, withdrawal, balance, inter-account transfer) and enforces a per-session withdrawal cap, ATM cash capacity and an inactivity timeout. It sits between the keypad/card front end and the display/cash-dispenser back end inside the ATM top level.

## Interface
- NUM_ACCOUNTS, 8: number of account records; IDX_W = $clog2(NUM_ACCOUNTS)
- BAL_W, 16: account balance and ATM cash width
- AMT_W, 15: transaction amount width
- PWD_W, 16: password width
- MAX_TRIES, 3: wrong passwords before lockout
- SESSION_LIMIT, 1000: max total withdrawn per session
- TIMEOUT_CYCLES, 1024: inactivity cycles in AUTH/MENU before forced end
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  write account record (IDLE only, ignored elsewhere)
- cfg_idx  in  IDX_W  account index for cfg_we
- cfg_pwd  in  PWD_W  password to store
- cfg_bal  in  BAL_W  balance to store; also clears that account's lock
- atm_init  in  1  load cash_avail from atm_capacity (IDLE only)
- atm_capacity  in  BAL_W  initial cash in machine
- insert  in  1  card-inserted pulse
- card_idx  in  IDX_W  account on inserted card
- card_valid  in  1  card readable; sampled with insert
- password  in  PWD_W  entered password
- op  in  2  0 deposit, 1 withdraw, 2 balance, 3 transfer
- amount  in  AMT_W  operation amount (zero-extended to BAL_W)
- dest_idx  in  IDX_W  transfer destination
- enter  in  1  confirm pulse
- cancel  in  1  end-session pulse
- balance_out  out  BAL_W  source balance after last successful op; reset 0
- cash_avail  out  BAL_W  cash remaining in machine; reset 0
- done  out  1  one-cycle success pulse; reset 0
- err_valid  out  1  one-cycle error pulse; reset 0
- err_code  out  4  0 NONE, 1 BAD_CARD, 2 BAD_PWD, 3 LOCKED, 4 INSUFF, 5 NO_CASH, 6 LIMIT, 7 OVERFLOW, 8 BAD_DEST, 9 TIMEOUT; held until next pulse; reset 0
- card_eject  out  1  one-cycle pulse, card returned; reset 0
- card_retained  out  1  one-cycle pulse, card swallowed; reset 0
- busy  out  1  high when not IDLE; reset 0

## Operation
- States: IDLE, AUTH, MENU, EXEC. Reset sets state IDLE and clears all balances, passwords, locks, tries counter, session-withdrawn total, timeout counter and cash_avail.
- IDLE:
  - insert with card_valid=1 and unlocked card_idx: latch card_idx as src, tries=0, go to AUTH.
  - insert with card_valid=0: err BAD_CARD plus card_eject.
  - insert on a locked account: err LOCKED plus card_retained.
  - cfg_we and atm_init are both honoured when they coincide with insert.
- AUTH, on enter:
  - Password match: go to MENU, session total=0.
  - Mismatch: increment tries and pulse err BAD_PWD.
  - Mismatch when tries reaches MAX_TRIES: set the lock bit, pulse err LOCKED plus card_retained, go to IDLE.
- MENU, on enter: latch op/amount/dest_idx, go to EXEC.
- EXEC (one cycle): evaluate the op, commit or reject, return to MENU.
  - Deposit: OVERFLOW if bal+amount exceeds BAL_W, else bal += amount.
  - Withdraw: checks in priority order LIMIT (total+amount > SESSION_LIMIT), INSUFF (amount > bal), NO_CASH (amount > cash_avail). On pass, bal -= amount, cash_avail -= amount, total += amount.
  - Balance: no state change.
  - Transfer: checks in priority order BAD_DEST (dest ≥ NUM_ACCOUNTS or dest == src), INSUFF, OVERFLOW on destination. On pass, both balances are updated in the same cycle.
  - Success: done pulse and balance_out update. Failure: err pulse only, no memory change.
- Ending a session:
  - cancel in AUTH/MENU: card_eject, go to IDLE, err unchanged.
  - Timeout: the counter runs in AUTH/MENU and clears on enter or state entry. Reaching TIMEOUT_CYCLES gives err TIMEOUT plus card_eject, go to IDLE.
- Priorities and ignored inputs:
  - cancel beats enter in the same cycle; timeout beats both.
  - insert outside IDLE is ignored.
  - Zero amounts succeed with no change.
  - cancel during EXEC is ignored; the op commits.
- Asynchronous rst mid-session clears everything to reset values; no eject pulse is issued.

## Timing
- All outputs are registered.
- Enter in AUTH sampled at edge k: result pulse visible after edge k+1.
- Enter in MENU sampled at edge k: EXEC during cycle k+1, done or err pulse after edge k+2.
- Next MENU enter is accepted from edge k+2.
- IDLE insert responses appear one cycle after the sampling edge.
- Timeout fires at the edge where the count equals TIMEOUT_CYCLES after the last enter.

## Test plan
- cfg acct 2 (pwd 0x1234, bal 500), atm_capacity 800; insert idx 2, enter 0x1234, withdraw 200 -> done, balance_out 300, cash_avail 600.
- Three wrong passwords on acct 2 -> BAD_PWD, BAD_PWD, then LOCKED plus card_retained; re-insert idx 2 -> LOCKED plus card_retained; cfg_we idx 2 unlocks.
- Session-limit run, acct bal 5000, cash 5000: withdraw 600 (done), then withdraw 500 -> LIMIT, balance_out stays 4400; then withdraw 400 -> done.
- Transfer 100 from acct 1 (bal 50) -> INSUFF; transfer to dest == src -> BAD_DEST; deposit to bal 65500 of 100 -> OVERFLOW; all with no memory change.
- Stay idle in MENU for TIMEOUT_CYCLES -> TIMEOUT plus card_eject, busy low.
- enter and cancel in the same MENU cycle -> card_eject only, no EXEC; assert rst mid-EXEC -> all outputs 0.
